// File: rtl/mshr_pkg.sv
// mshr_pkg: shared widths and issuer state encoding for the MSHR drain path
package mshr_pkg;
  localparam int ADDR_TAG_BITS = 20;
  localparam int DATA_BITS = 90;
  localparam int LINE_BITS = 256;
  typedef enum logic {IDLE, REQ} issuer_state_e;
endpackage

// File: rtl/mshr_credit_counter.sv
// mshr_credit_counter: in-flight request count saturating at 0 and MAX_OUTSTANDING
module mshr_credit_counter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_BITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CNT_BITS-1:0] count_o,
  output logic                full_o,
  output logic                underflow_o
);
  localparam logic [CNT_BITS-1:0] MAX = CNT_BITS'(MAX_OUTSTANDING);
  logic [CNT_BITS-1:0] count_q, count_d;
  assign count_o = count_q;
  assign full_o = count_q == MAX;
  // A simultaneous inc/dec cancels, so only a lone decrement at zero is an underflow
  assign underflow_o = dec_i && !inc_i && count_q == '0;
  always_comb begin
    count_d = inc_i && !dec_i && !full_o ? count_q + 1'b1 :
              dec_i && !inc_i && count_q != '0 ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) count_q <= '0;
    else count_q <= count_d;
  end
endmodule

// File: rtl/mshr_mem_issuer.sv
// mshr_mem_issuer: pops MSHR entries, issues them to memory under a credit limit,
// and retires entries / forwards fill lines on memory responses.
module mshr_mem_issuer import mshr_pkg::*; #(
  parameter int ADDR_TAG_BITS = mshr_pkg::ADDR_TAG_BITS,
  parameter int DATA_BITS = mshr_pkg::DATA_BITS,
  parameter int LINE_BITS = mshr_pkg::LINE_BITS,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mshr_read_valid,
  input  logic [ADDR_TAG_BITS-1:0] mshr_read_tag,
  input  logic [DATA_BITS-1:0]     mshr_read_data,
  output logic                     mshr_read_next,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_TAG_BITS-1:0] mem_req_tag,
  output logic [DATA_BITS-1:0]     mem_req_data,
  input  logic                     mem_resp_valid,
  input  logic [ADDR_TAG_BITS-1:0] mem_resp_tag,
  input  logic [LINE_BITS-1:0]     mem_resp_line,
  output logic                     mshr_del,
  output logic [ADDR_TAG_BITS-1:0] mshr_del_tag,
  output logic                     fill_valid,
  output logic [ADDR_TAG_BITS-1:0] fill_tag,
  output logic [LINE_BITS-1:0]     fill_line,
  output logic [CNT_BITS-1:0]      outstanding,
  output logic                     resp_err
);
  issuer_state_e state_q, state_d;
  logic [ADDR_TAG_BITS-1:0] req_tag_q, resp_tag_q;
  logic [DATA_BITS-1:0] req_data_q;
  logic [LINE_BITS-1:0] resp_line_q;
  logic resp_v_q, err_q, full, underflow, cap, hs;
  assign cap = state_q == IDLE && enable && mshr_read_valid && !full;
  assign hs = state_q == REQ && mem_req_ready;
  mshr_credit_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .CNT_BITS(CNT_BITS)) u_credit (
    .clk_i(clk), .rst_ni(reset), .inc_i(hs), .dec_i(mem_resp_valid),
    .count_o(outstanding), .full_o(full), .underflow_o(underflow)
  );
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? (cap ? REQ : IDLE) : (mem_req_ready ? IDLE : REQ);
  end
  always_comb begin
    mshr_read_next = cap;
    mem_req_valid = state_q == REQ;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_tag_q <= '0;
      req_data_q <= '0;
      resp_v_q <= 1'b0;
      resp_tag_q <= '0;
      resp_line_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (cap) begin
        req_tag_q <= mshr_read_tag;
        req_data_q <= mshr_read_data;
      end
      resp_v_q <= mem_resp_valid && !underflow;
      if (mem_resp_valid) begin
        resp_tag_q <= mem_resp_tag;
        resp_line_q <= mem_resp_line;
      end
      err_q <= err_q || underflow;
    end
  end
  assign mem_req_tag = req_tag_q;
  assign mem_req_data = req_data_q;
  assign mshr_del = resp_v_q;
  assign mshr_del_tag = resp_tag_q;
  assign fill_valid = resp_v_q;
  assign fill_tag = resp_tag_q;
  assign fill_line = resp_line_q;
  assign resp_err = err_q;
endmodule

// File: doc/mshr_mem_issuer.md
# mshr_mem_issuer

Downstream drain stage of the MSHR. Pops pending miss entries from the MSHR read port, issues them to the memory interface with a valid/ready handshake, and limits in-flight requests with a credit counter. On each memory response it retires the matching MSHR entry by tag and forwards the fill line to the cache.

## Interface
Parameters:
- ADDR_TAG_BITS, 20, miss address tag width (matches MSHR)
- DATA_BITS, 90, MSHR entry payload width
- LINE_BITS, 256, fill line width returned by memory
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered requests (1..15)
- CNT_BITS, 4, width of outstanding count; must hold MAX_OUTSTANDING

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- enable  in  1  permits capture of new MSHR entries
- mshr_read_valid  in  1  MSHR head entry valid
- mshr_read_tag  in  ADDR_TAG_BITS  head entry tag
- mshr_read_data  in  DATA_BITS  head entry payload
- mshr_read_next  out  1  advance MSHR read pointer (combinational, one cycle)
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_tag  out  ADDR_TAG_BITS  request tag
- mem_req_data  out  DATA_BITS  request payload
- mem_resp_valid  in  1  response valid (always accepted, no ready)
- mem_resp_tag  in  ADDR_TAG_BITS  response tag
- mem_resp_line  in  LINE_BITS  response line
- mshr_del  out  1  delete entry in MSHR
- mshr_del_tag  out  ADDR_TAG_BITS  tag to delete
- fill_valid  out  1  fill line valid to cache
- fill_tag  out  ADDR_TAG_BITS  fill tag
- fill_line  out  LINE_BITS  fill data
- outstanding  out  CNT_BITS  in-flight request count
- resp_err  out  1  sticky: response received with outstanding == 0

## Operation
- FSM states: IDLE, REQ.
- IDLE: if enable && mshr_read_valid && outstanding < MAX_OUTSTANDING, capture tag/data into request registers, assert mshr_read_next this cycle, go REQ. Otherwise stay.
- REQ: mem_req_valid = 1; tag/data held stable until mem_req_ready. On handshake go IDLE, outstanding increments.
- enable = 0 blocks only the IDLE capture; REQ and the response path keep running. A request, once valid, is never withdrawn.
- Response path independent of FSM: mem_resp_valid registered; next cycle mshr_del = 1 with mshr_del_tag = mem_resp_tag and fill_valid = 1 with fill_tag/fill_line; outstanding decrements.
- Handshake and response in the same cycle: outstanding unchanged.
- Response when outstanding == 0 (and no handshake that cycle): no del, no fill, count stays 0, resp_err set until reset.
- No tag matching against issued requests; memory returns only issued tags.

## Timing
- Reset (reset = 0 at edge): state IDLE, all outputs 0, request/fill registers 0, outstanding 0, resp_err 0. Applies mid-operation: pending request dropped, in-flight responses arriving afterwards raise resp_err.
- Entry capture to mem_req_valid: 1 cycle. Peak issue rate: one request per 2 cycles (IDLE + REQ).
- mem_resp_valid to mshr_del/fill_valid: 1 cycle, each a single-cycle pulse per response; back-to-back responses give back-to-back pulses.
- Capture blocked whenever outstanding == MAX_OUTSTANDING; a response retiring in cycle N allows capture in cycle N+1.
- mshr_read_next is asserted only in the IDLE capture cycle, never in REQ, so the MSHR head has advanced before the next IDLE sample.

## Structure
- Shared package mshr_pkg: ADDR_TAG_BITS, DATA_BITS, LINE_BITS defaults, and the issuer state enum (IDLE, REQ).
- One sub-module: mshr_credit_counter (inc, dec, count, full, underflow flag), saturating at 0 and MAX_OUTSTANDING.

## Test plan
- Reset then MSHR offers tag 1/data 100, mem_req_ready = 1 -> mshr_read_next pulse, mem_req_valid with tag 1 one cycle later, outstanding = 1.
- Four entries (tags 2..5), ready = 1, no responses, MAX_OUTSTANDING = 4 -> four requests issued, fifth entry (tag 6) not popped until a response for tag 2 arrives; tag 6 is then captured the next cycle.
- mem_req_ready held 0 for 3 cycles in REQ with tag 7 -> valid/tag/data stable, no further mshr_read_next, issue completes when ready = 1.
- Response tag 3, line 0xABCD -> next cycle mshr_del = 1 tag 3, fill_valid = 1 tag 3 line 0xABCD, outstanding decrements.
- Handshake (tag 8) and response (tag 4) in the same cycle at outstanding = 2 -> outstanding stays 2, del/fill for tag 4 next cycle.
- Response with outstanding = 0 -> no del/fill, resp_err = 1 and held; reset = 0 for one cycle clears it and all outputs.
